// File: rtl/ili9341_frame_scheduler_if.sv
// Pixel stream between the frame scheduler and the ILI9341 controller pixel port.
// A pixel moves on any cycle where pix_valid and pix_ready are both high.
interface ili9341_frame_scheduler_if #(
    parameter int unsigned PIXEL_SIZE = 16
);
    logic [PIXEL_SIZE-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_ready;

    modport master (
        output pix_data,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/ili9341_frame_scheduler.sv
// Frame sequencer: walks the output raster of one scene per frame, upscaling the sprite ROM or
// emitting a solid colour, and hands pixels to the controller one at a time.
module ili9341_frame_scheduler #(
    parameter int unsigned SRC_W      = 80,
    parameter int unsigned SRC_H      = 80,
    parameter int unsigned SCALE      = 3,
    parameter int unsigned PIXEL_SIZE = 16,
    parameter int unsigned NUM_SCENES = 5,
    localparam int unsigned ADDR_W    = $clog2(SRC_W * SRC_H)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             scene_sel,
    input  logic                   scene_req,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [PIXEL_SIZE-1:0]  rom_data,
    ili9341_frame_scheduler_if.master pix,
    output logic                   frame_start,
    output logic                   frame_done,
    output logic                   busy,
    output logic [2:0]             active_scene
);

    localparam int unsigned XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int unsigned YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int unsigned RW = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [XW-1:0]     X_LAST   = XW'(SRC_W - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(SRC_H - 1);
    localparam logic [RW-1:0]     REP_LAST = RW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPresent,
        StDone
    } state_e;

    state_e            state_q;
    logic              pending_q;
    logic [2:0]        pend_scene_q;
    logic [RW-1:0]     sx_rep_q, sy_rep_q;
    logic [XW-1:0]     src_x_q;
    logic [YW-1:0]     src_y_q;
    logic [ADDR_W-1:0] row_base_q;

    logic [RW-1:0]     sx_rep_n, sy_rep_n;
    logic [XW-1:0]     src_x_n;
    logic [YW-1:0]     src_y_n;
    logic [ADDR_W-1:0] row_base_n;
    logic              last_pix;

    function automatic logic [PIXEL_SIZE-1:0] solid_colour(input logic [2:0] scene);
        if (32'(scene) >= NUM_SCENES) begin
            return PIXEL_SIZE'(16'h001F);
        end
        case (scene)
            3'd1:    return PIXEL_SIZE'(16'h07FF);
            3'd2:    return PIXEL_SIZE'(16'hF800);
            3'd3:    return PIXEL_SIZE'(16'h780F);
            default: return PIXEL_SIZE'(16'h0000);
        endcase
    endfunction

    // Raster position after the current pixel; row_base only advances once a source row has
    // been repeated SCALE times, so no multiply is needed for the ROM address.
    always_comb begin
        sx_rep_n   = sx_rep_q + RW'(1);
        src_x_n    = src_x_q;
        sy_rep_n   = sy_rep_q;
        src_y_n    = src_y_q;
        row_base_n = row_base_q;
        if (sx_rep_q == REP_LAST) begin
            sx_rep_n = '0;
            if (src_x_q == X_LAST) begin
                src_x_n = '0;
                if (sy_rep_q != REP_LAST) begin
                    sy_rep_n = sy_rep_q + RW'(1);
                end else begin
                    sy_rep_n   = '0;
                    src_y_n    = src_y_q + YW'(1);
                    row_base_n = row_base_q + ROW_STEP;
                end
            end else begin
                src_x_n = src_x_q + XW'(1);
            end
        end
    end

    assign last_pix = (sx_rep_q == REP_LAST) && (src_x_q == X_LAST) &&
                      (sy_rep_q == REP_LAST) && (src_y_q == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            pending_q     <= 1'b1;
            pend_scene_q  <= 3'd0;
            active_scene  <= 3'd0;
            sx_rep_q      <= '0;
            sy_rep_q      <= '0;
            src_x_q       <= '0;
            src_y_q       <= '0;
            row_base_q    <= '0;
            rom_addr      <= '0;
            pix.pix_data  <= '0;
            pix.pix_valid <= 1'b0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            if (scene_req) begin
                pending_q    <= 1'b1;
                pend_scene_q <= scene_sel;
            end
            case (state_q)
                StIdle: begin
                    // A request arriving in this very cycle is the newest one and wins.
                    if (pending_q || scene_req) begin
                        active_scene <= scene_req ? scene_sel : pend_scene_q;
                        pending_q    <= 1'b0;
                        frame_start  <= 1'b1;
                        busy         <= 1'b1;
                        rom_addr     <= '0;
                        state_q      <= StFetch;
                    end
                end
                StFetch: begin
                    state_q <= StLoad;
                end
                StLoad: begin
                    pix.pix_data  <= (active_scene == 3'd0) ? rom_data
                                                            : solid_colour(active_scene);
                    pix.pix_valid <= 1'b1;
                    state_q       <= StPresent;
                end
                StPresent: begin
                    if (pix.pix_ready) begin
                        pix.pix_valid <= 1'b0;
                        if (last_pix) begin
                            sx_rep_q   <= '0;
                            sy_rep_q   <= '0;
                            src_x_q    <= '0;
                            src_y_q    <= '0;
                            row_base_q <= '0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            sx_rep_q   <= sx_rep_n;
                            sy_rep_q   <= sy_rep_n;
                            src_x_q    <= src_x_n;
                            src_y_q    <= src_y_n;
                            row_base_q <= row_base_n;
                            rom_addr   <= row_base_n + ADDR_W'(src_x_n);
                            state_q    <= StFetch;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ili9341_frame_scheduler.sv
// Randomised scoreboard bench for ili9341_frame_scheduler on a reduced 10x6 sprite so whole
// frames fit in a short run; the reference derives each pixel from its raster position.
module tb_ili9341_frame_scheduler;

    localparam int unsigned SRC_W      = 10;
    localparam int unsigned SRC_H      = 6;
    localparam int unsigned SCALE      = 3;
    localparam int unsigned PS         = 16;
    localparam int unsigned NUM_SCENES = 5;
    localparam int unsigned OUT_W      = SRC_W * SCALE;
    localparam int unsigned OUT_H      = SRC_H * SCALE;
    localparam int unsigned NPIX       = OUT_W * OUT_H;
    localparam int unsigned NSRC       = SRC_W * SRC_H;
    localparam int unsigned AW         = $clog2(NSRC);

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    scene_sel;
    logic          scene_req;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          frame_start;
    logic          frame_done;
    logic          busy;
    logic [2:0]    active_scene;

    ili9341_frame_scheduler_if #(.PIXEL_SIZE(PS)) pix_if ();

    ili9341_frame_scheduler #(
        .SRC_W      (SRC_W),
        .SRC_H      (SRC_H),
        .SCALE      (SCALE),
        .PIXEL_SIZE (PS),
        .NUM_SCENES (NUM_SCENES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .scene_sel    (scene_sel),
        .scene_req    (scene_req),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .pix          (pix_if),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .busy         (busy),
        .active_scene (active_scene)
    );

    always #5 clk = ~clk;

    logic [15:0] rom_mem [NSRC];

    function automatic logic [15:0] rom_read(input int a);
        if (a < int'(NSRC)) return rom_mem[a];
        return 16'hDEAD;
    endfunction

    always @(posedge clk) rom_data <= rom_read(int'(rom_addr));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference pixel k of a frame: raster position mapped back to the source by division.
    function automatic logic [15:0] exp_pix(input logic [2:0] sc, input int k);
        int ox;
        int oy;
        ox = k % int'(OUT_W);
        oy = k / int'(OUT_W);
        case (sc)
            3'd0:    return rom_mem[(oy / int'(SCALE)) * int'(SRC_W) + ox / int'(SCALE)];
            3'd1:    return 16'h07FF;
            3'd2:    return 16'hF800;
            3'd3:    return 16'h780F;
            3'd4:    return 16'h0000;
            default: return 16'h001F;
        endcase
    endfunction

    // Reference model state: describes what the DUT should show in the coming cycle.
    bit          m_idle, m_pending, exp_fs, exp_done, m_busy;
    bit          rst_seen = 1'b1;
    bit          hold_valid, first_pend, timing_chk, start, last;
    logic [2:0]  m_pscene, m_active, sc;
    logic [15:0] hold_data;
    logic [15:0] expq [$];
    int          frame_left, frame_xfers, cyc, fs_cyc, max_addr;

    always @(negedge clk) begin
        cyc++;
        last = 1'b0;
        if (rst_seen) begin
            chk("reset_outputs", 32'({rom_addr, pix_if.pix_data, pix_if.pix_valid, frame_start,
                                      frame_done, busy, active_scene}), 32'd0);
        end else begin
            chk("frame_start", 32'(frame_start), 32'(exp_fs));
            chk("frame_done", 32'(frame_done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(m_busy));
            if (exp_fs) begin
                chk("active_scene", 32'(active_scene), 32'(m_active));
                fs_cyc     = cyc;
                first_pend = 1'b1;
            end
            if (exp_done && timing_chk) chk("frame_cycles", 32'(cyc - fs_cyc), 32'(3 * NPIX));
            if (first_pend && pix_if.pix_valid) begin
                if (timing_chk) chk("first_pixel_latency", 32'(cyc - fs_cyc), 32'd2);
                first_pend = 1'b0;
            end
            if (hold_valid) begin
                chk("hold_valid", 32'(pix_if.pix_valid), 32'd1);
                chk("hold_data", 32'(pix_if.pix_data), 32'(hold_data));
            end
            if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            if (pix_if.pix_valid && pix_if.pix_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_pixel", 32'(pix_if.pix_data), 32'hFFFF_FFFF);
                end else begin
                    chk("pixel", 32'(pix_if.pix_data), 32'(expq.pop_front()));
                    frame_left--;
                    frame_xfers++;
                    last = (frame_left == 0);
                end
            end
        end

        if (rst) begin
            m_idle     = 1'b1;
            m_pending  = 1'b1;
            m_pscene   = 3'd0;
            exp_fs     = 1'b0;
            exp_done   = 1'b0;
            m_busy     = 1'b0;
            expq.delete();
            frame_left  = 0;
            frame_xfers = 0;
            hold_valid  = 1'b0;
            first_pend  = 1'b0;
            rst_seen    = 1'b1;
        end else begin
            rst_seen   = 1'b0;
            hold_valid = pix_if.pix_valid && !pix_if.pix_ready;
            hold_data  = pix_if.pix_data;
            start      = m_idle && (m_pending || scene_req);
            if (start) begin
                sc        = scene_req ? scene_sel : m_pscene;
                m_active  = sc;
                m_pending = 1'b0;
                expq.delete();
                for (int k = 0; k < int'(NPIX); k++) expq.push_back(exp_pix(sc, k));
                frame_left  = NPIX;
                frame_xfers = 0;
            end else if (scene_req) begin
                m_pending = 1'b1;
                m_pscene  = scene_sel;
            end
            m_idle   = start ? 1'b0 : (exp_done ? 1'b1 : m_idle);
            m_busy   = start ? 1'b1 : (last ? 1'b0 : m_busy);
            exp_done = last;
            exp_fs   = start;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] s);
        scene_sel = s;
        scene_req = 1'b1;
        step();
        scene_req = 1'b0;
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        step();
        while (!frame_done && b < 8 * 3 * int'(NPIX)) begin
            step();
            b++;
        end
        if (!frame_done) chk("frame_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int b;
        for (int i = 0; i < int'(NSRC); i++) rom_mem[i] = 16'($urandom);
        rst              = 1'b1;
        scene_req        = 1'b0;
        scene_sel        = 3'd0;
        pix_if.pix_ready = 1'b1;
        timing_chk       = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Sprite frame from reset, with a mid-frame request for scene 2.
        repeat (NPIX) step();
        req(3'd2);
        wait_done();
        wait_done();
        repeat (10) step();

        // Idle request starts at once; two mid-frame requests, the last one wins.
        req(3'd3);
        repeat (NPIX) step();
        req(3'd1);
        req(3'd4);
        wait_done();
        wait_done();
        repeat (10) step();

        // Random back-pressure and random scene requests.
        timing_chk = 1'b0;
        req(3'd0);
        for (int i = 0; i < 12000; i++) begin
            pix_if.pix_ready = ($urandom_range(0, 99) >= 30);
            if ($urandom_range(0, 299) == 0) begin
                scene_req = 1'b1;
                scene_sel = 3'($urandom_range(0, 7));
            end else begin
                scene_req = 1'b0;
            end
            step();
        end
        scene_req        = 1'b0;
        pix_if.pix_ready = 1'b1;
        repeat (2 * 3 * NPIX + 20) step();

        // Reset in the middle of a frame.
        req(3'd0);
        b = 0;
        while (frame_xfers < 100 && b < 5000) begin
            step();
            b++;
        end
        if (frame_xfers < 100) chk("reset_point_timeout", 32'(frame_xfers), 32'd100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_done();
        repeat (10) step();

        // Out-of-range scene, then a request landing on the DONE cycle.
        req(3'd6);
        b = 0;
        while (!frame_done && b < 8 * 3 * int'(NPIX)) begin
            step();
            b++;
        end
        if (!frame_done) chk("done_cycle_timeout", 32'd0, 32'd1);
        scene_sel = 3'd1;
        scene_req = 1'b1;
        step();
        scene_req = 1'b0;
        wait_done();
        repeat (10) step();

        chk("rom_addr_max", 32'(max_addr), 32'(NSRC - 1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
